// File: rtl/e_hazard_ctrl.sv
// E-stage hazard/forwarding controller: combinational stall, registered ALU operand forward selects,
// and an MDU busy countdown that is built only when HAZARD_MDU_EN is defined.
module e_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Req,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic       D_IsMDU,
  input  logic [4:0] E_A3,
  input  logic [4:0] M_A3,
  input  logic [1:0] E_Tnew,
  input  logic [1:0] M_Tnew,
  input  logic       E_MDUStart,
  input  logic       E_MDUIsDiv,
  output logic       Stall,
  output logic [1:0] E_ForwardALUAMux_Sel,
  output logic [1:0] E_ForwardALUBMux_Sel,
  output logic       MDU_Busy
);

  localparam logic [1:0] SEL_GRF = 2'd0;
  localparam logic [1:0] SEL_W   = 2'd1;
  localparam logic [1:0] SEL_M   = 2'd2;

  function automatic logic reg_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                     input logic [4:0] m_a3, input logic [1:0] m_tnew);
    reg_stall = (src != 5'd0) &&
                (((src == e_a3) && (tuse < e_tnew)) || ((src == m_a3) && (tuse < m_tnew)));
  endfunction

  // The E writer is the newest, so it wins over M; it will sit in M next cycle.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] e_a3,
                                         input logic [4:0] m_a3);
    if (src == 5'd0)       fwd_sel = SEL_GRF;
    else if (src == e_a3)  fwd_sel = SEL_M;
    else if (src == m_a3)  fwd_sel = SEL_W;
    else                   fwd_sel = SEL_GRF;
  endfunction

  logic       stall_rs, stall_rt, stall_mdu;
  logic [1:0] sel_a_d, sel_a_q, sel_b_d, sel_b_q;

  always_comb begin
    stall_rs = reg_stall(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
    stall_rt = reg_stall(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
  end

  assign Stall = stall_rs | stall_rt | stall_mdu;

  always_comb begin
    sel_a_d = fwd_sel(D_rs, E_A3, M_A3);
    sel_b_d = fwd_sel(D_rt, E_A3, M_A3);
    if (Req || Stall) begin
      sel_a_d = SEL_GRF;
      sel_b_d = SEL_GRF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_a_q <= SEL_GRF;
      sel_b_q <= SEL_GRF;
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign E_ForwardALUAMux_Sel = sel_a_q;
  assign E_ForwardALUBMux_Sel = sel_b_q;

`ifdef HAZARD_MDU_EN
  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [3:0] cnt_d, cnt_q;

  // A flushed start is dropped, but Req never aborts a countdown already running.
  always_comb begin
    cnt_d = cnt_q;
    if (E_MDUStart && !Req)   cnt_d = E_MDUIsDiv ? DIV_LD : MULT_LD;
    else if (cnt_q != 4'd0)   cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

  assign MDU_Busy  = (cnt_q != 4'd0);
  assign stall_mdu = D_IsMDU & (MDU_Busy | E_MDUStart);
`else
  logic unused_mdu;
  assign unused_mdu = ^{E_MDUStart, E_MDUIsDiv, D_IsMDU, 4'(MULT_CYCLES), 4'(DIV_CYCLES)};
  assign MDU_Busy   = 1'b0;
  assign stall_mdu  = 1'b0;
`endif

endmodule

// File: tb/tb_e_hazard_ctrl.sv
// Directed self-checking bench for e_hazard_ctrl; MDU expectations follow HAZARD_MDU_EN.
module tb_e_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset, Req, D_IsMDU, E_MDUStart, E_MDUIsDiv;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       Stall, MDU_Busy;
  logic [1:0] sel_a, sel_b;
  int checks = 0;
  int failures = 0;
  int nstall;

`ifdef HAZARD_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  e_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Req(Req),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_IsMDU(D_IsMDU), .E_A3(E_A3), .M_A3(M_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
    .E_MDUStart(E_MDUStart), .E_MDUIsDiv(E_MDUIsDiv),
    .Stall(Stall), .E_ForwardALUAMux_Sel(sel_a), .E_ForwardALUBMux_Sel(sel_b),
    .MDU_Busy(MDU_Busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Req = 0; D_IsMDU = 0; E_MDUStart = 0; E_MDUIsDiv = 0;
    D_rs = 0; D_rt = 0; E_A3 = 0; M_A3 = 0;
    D_Tuse_rs = 3; D_Tuse_rt = 3; E_Tnew = 0; M_Tnew = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Holds D_IsMDU for a window after a single start pulse and counts stalled cycles.
  task automatic mdu_run(input logic is_div, output int n);
    n = 0;
    idle(); D_IsMDU = 1; E_MDUStart = 1; E_MDUIsDiv = is_div;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (Stall) n++;
      tick();
      E_MDUStart = 0;
    end
    idle();
  endtask

  initial begin
    idle(); reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    check("reset_sel_a", sel_a, 0);
    check("reset_sel_b", sel_b, 0);
    check("reset_busy", MDU_Busy, 0);
    check("reset_stall", Stall, 0);

    // ALU forward from E on both operands
    D_rs = 5; D_rt = 5; E_A3 = 5; E_Tnew = 1; D_Tuse_rs = 1; D_Tuse_rt = 1; #1;
    check("alu_fwd_stall", Stall, 0);
    tick();
    check("alu_fwd_sel_a", sel_a, 2);
    check("alu_fwd_sel_b", sel_b, 2);

    // Load-use on rs: stall forces selects to 0 although next select would be 2
    idle(); D_rs = 8; D_Tuse_rs = 0; E_A3 = 8; E_Tnew = 2; #1;
    check("lu_stall_e", Stall, 1);
    tick();
    check("lu_sel_a_bubble", sel_a, 0);
    E_A3 = 0; E_Tnew = 0; M_A3 = 8; M_Tnew = 1; #1;
    check("lu_stall_m", Stall, 1);
    tick();
    M_Tnew = 0; #1;
    check("lu_release", Stall, 0);
    tick();
    check("lu_sel_a_w", sel_a, 1);

    // Register 0 never hazards or forwards
    idle(); D_rs = 0; E_A3 = 0; E_Tnew = 2; D_Tuse_rs = 0; #1;
    check("r0_stall", Stall, 0);
    tick();
    check("r0_sel_a", sel_a, 0);

    // rt stall from M writer
    idle(); D_rt = 12; D_Tuse_rt = 1; M_A3 = 12; M_Tnew = 2; #1;
    check("rt_stall_m", Stall, 1);
    D_Tuse_rt = 3; #1;
    check("rt_tuse3", Stall, 0);

    // E beats M when both write the same register; M-only gives W select
    idle(); D_rt = 9; D_Tuse_rt = 1; E_A3 = 9; M_A3 = 9; #1;
    check("prio_stall", Stall, 0);
    tick();
    check("prio_sel_b", sel_b, 2);
    E_A3 = 3; tick();
    check("m_only_sel_b", sel_b, 1);
    check("m_only_sel_a", sel_a, 0);

    // MDU busy windows
    mdu_run(1'b1, nstall);
    check("mdu_div_stalls", nstall, MDU_ON ? 11 : 0);
    mdu_run(1'b0, nstall);
    check("mdu_mult_stalls", nstall, MDU_ON ? 6 : 0);

    // Flush: start dropped, pending select of 2 cleared
    idle(); D_rs = 5; D_rt = 5; E_A3 = 5; E_Tnew = 0; D_Tuse_rs = 1; D_Tuse_rt = 1;
    Req = 1; E_MDUStart = 1; E_MDUIsDiv = 1;
    tick();
    check("flush_sel_a", sel_a, 0);
    check("flush_sel_b", sel_b, 0);
    check("flush_busy", MDU_Busy, 0);

    // Req during a running div count leaves it untouched
    idle(); E_MDUStart = 1; E_MDUIsDiv = 1;
    tick();
    E_MDUStart = 0; Req = 1;
    for (int i = 0; i < 8; i++) tick();
    check("req_count_busy", MDU_Busy, MDU_ON ? 1 : 0);
    tick();
    check("req_count_last", MDU_Busy, MDU_ON ? 1 : 0);
    tick();
    check("req_count_done", MDU_Busy, 0);

    // Reset mid-count clears immediately
    idle(); E_MDUStart = 1; E_MDUIsDiv = 1;
    tick();
    E_MDUStart = 0;
    tick();
    check("pre_reset_busy", MDU_Busy, MDU_ON ? 1 : 0);
    reset = 1; tick(); reset = 0;
    check("mid_reset_busy", MDU_Busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
